// File: rtl/ecc_result_deser_pkg.sv
// Shared constants for the ECC result deserialiser: result width, curve mode codes and the
// width-from-mode lookup.
package ecc_result_deser_pkg;

    localparam int unsigned ECC_MAX_BITS = 256;

    typedef enum logic [1:0] {
        Bits32  = 2'd0,
        Bits64  = 2'd1,
        Bits128 = 2'd2,
        Bits256 = 2'd3
    } ecc_mode_e;

    function automatic int unsigned width_from_mode(input logic [1:0] mode);
        int unsigned w;
        unique case (mode)
            Bits32:  w = 32;
            Bits64:  w = 64;
            Bits128: w = 128;
            default: w = 256;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ecc_ser2par_chan.sv
// One serial-to-parallel channel: frames an MSB-first x/y bit pair stream, counts bits and
// either commits the assembled words or flags a length error when the frame ends.
module ecc_ser2par_chan
    import ecc_result_deser_pkg::*;
#(
    parameter int unsigned MAX_BITS = ECC_MAX_BITS,
    parameter int unsigned CNT_W    = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          i_mode,
    input  logic                i_valid,
    input  logic                i_x,
    input  logic                i_y,
    output logic                o_commit,
    output logic                o_len_err,
    output logic [MAX_BITS-1:0] o_x,
    output logic [MAX_BITS-1:0] o_y
);

    typedef enum logic [0:0] {StIdle, StShift} chan_state_e;

    localparam logic [CNT_W-1:0] CntSat = CNT_W'(MAX_BITS + 1);

    chan_state_e         state_q, state_d;
    logic [MAX_BITS-1:0] sr_x_q, sr_x_d, sr_y_q, sr_y_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    width_q, width_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            sr_x_q  <= '0;
            sr_y_q  <= '0;
            cnt_q   <= '0;
            width_q <= '0;
        end else begin
            state_q <= state_d;
            sr_x_q  <= sr_x_d;
            sr_y_q  <= sr_y_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_x_d    = sr_x_q;
        sr_y_d    = sr_y_q;
        cnt_d     = cnt_q;
        width_d   = width_q;
        o_commit  = 1'b0;
        o_len_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_valid) begin
                    width_d = CNT_W'(width_from_mode(i_mode));
                    sr_x_d  = {{(MAX_BITS-1){1'b0}}, i_x};
                    sr_y_d  = {{(MAX_BITS-1){1'b0}}, i_y};
                    cnt_d   = CNT_W'(1);
                    state_d = StShift;
                end
            end
            StShift: begin
                if (i_valid) begin
                    sr_x_d = {sr_x_q[MAX_BITS-2:0], i_x};
                    sr_y_d = {sr_y_q[MAX_BITS-2:0], i_y};
                    // Saturate so an over-long frame can never wrap back to a legal length.
                    cnt_d  = (cnt_q == CntSat) ? cnt_q : cnt_q + CNT_W'(1);
                end else begin
                    o_commit  = (cnt_q == width_q);
                    o_len_err = (cnt_q != width_q);
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_x = sr_x_q;
    assign o_y = sr_y_q;

endmodule

// File: rtl/ecc_result_deser.sv
// Captures the mP/mnP serial result streams, double-buffers them and presents one tagged
// result at a time over valid/ready. Optional range check: ECC_DESER_RANGE_CHK_EN.
module ecc_result_deser
    import ecc_result_deser_pkg::*;
#(
    parameter int unsigned MAX_BITS = ECC_MAX_BITS,
    parameter int unsigned CNT_W    = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          i_mode,
    input  logic                i_mP_valid,
    input  logic                i_mPx,
    input  logic                i_mPy,
    input  logic                i_mnP_valid,
    input  logic                i_mnPx,
    input  logic                i_mnPy,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_tag,
    output logic [MAX_BITS-1:0] o_x,
    output logic [MAX_BITS-1:0] o_y,
    output logic                o_len_err,
    output logic                o_ovf_err,
`ifdef ECC_DESER_RANGE_CHK_EN
    input  logic [MAX_BITS-1:0] i_prime,
    output logic                o_range_err,
`endif
    input  logic                i_clr_err
);

    logic [1:0]                commit, len_set;
    logic [1:0][MAX_BITS-1:0]  ch_x, ch_y;

    ecc_ser2par_chan #(.MAX_BITS(MAX_BITS), .CNT_W(CNT_W)) u_chan_mp (
        .clk       (clk),
        .rst       (rst),
        .i_mode    (i_mode),
        .i_valid   (i_mP_valid),
        .i_x       (i_mPx),
        .i_y       (i_mPy),
        .o_commit  (commit[0]),
        .o_len_err (len_set[0]),
        .o_x       (ch_x[0]),
        .o_y       (ch_y[0])
    );

    ecc_ser2par_chan #(.MAX_BITS(MAX_BITS), .CNT_W(CNT_W)) u_chan_mnp (
        .clk       (clk),
        .rst       (rst),
        .i_mode    (i_mode),
        .i_valid   (i_mnP_valid),
        .i_x       (i_mnPx),
        .i_y       (i_mnPy),
        .o_commit  (commit[1]),
        .o_len_err (len_set[1]),
        .o_x       (ch_x[1]),
        .o_y       (ch_y[1])
    );

    logic [1:0]               full_q, full_d;
    logic [1:0][MAX_BITS-1:0] buf_x_q, buf_x_d, buf_y_q, buf_y_d;
    logic                     sel_q, sel_d, lock_q, lock_d, sel, handshake, drain;
    logic                     len_err_q, len_err_d, ovf_err_q, ovf_err_d, ovf_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q    <= '0;
            buf_x_q   <= '0;
            buf_y_q   <= '0;
            sel_q     <= 1'b0;
            lock_q    <= 1'b0;
            len_err_q <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            buf_x_q   <= buf_x_d;
            buf_y_q   <= buf_y_d;
            sel_q     <= sel_d;
            lock_q    <= lock_d;
            len_err_q <= len_err_d;
            ovf_err_q <= ovf_err_d;
        end
    end

    always_comb begin
        // Unlocked: mP has priority; tag idles at 0 when nothing is buffered.
        sel       = lock_q ? sel_q : (~full_q[0] & full_q[1]);
        o_valid   = full_q[sel];
        o_tag     = sel;
        o_x       = buf_x_q[sel];
        o_y       = buf_y_q[sel];
        handshake = o_valid & i_ready;
        lock_d    = o_valid & ~i_ready;
        sel_d     = sel;
        full_d    = full_q;
        buf_x_d   = buf_x_q;
        buf_y_d   = buf_y_q;
        ovf_set   = 1'b0;
        drain     = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drain = handshake && (sel == 1'(c));
            if (drain) begin
                full_d[c] = 1'b0;
            end
            if (commit[c]) begin
                if (!full_q[c] || drain) begin
                    full_d[c]  = 1'b1;
                    buf_x_d[c] = ch_x[c];
                    buf_y_d[c] = ch_y[c];
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end
        len_err_d = (|len_set) | (len_err_q & ~i_clr_err);
        ovf_err_d = ovf_set | (ovf_err_q & ~i_clr_err);
    end

    assign o_len_err = len_err_q;
    assign o_ovf_err = ovf_err_q;

`ifdef ECC_DESER_RANGE_CHK_EN
    logic range_err_q, range_err_d, range_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end

    always_comb begin
        range_set = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (commit[c] && ((ch_x[c] >= i_prime) || (ch_y[c] >= i_prime))) begin
                range_set = 1'b1;
            end
        end
        range_err_d = range_set | (range_err_q & ~i_clr_err);
    end

    assign o_range_err = range_err_q;
`endif

endmodule
